// File: rtl/elevator_car_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_car_ctrl_if
// Brief    : Request/position bus between the car controller and its users.
// Revision : 1.0 - initial release
// ============================================================================
interface elevator_car_ctrl_if;
    logic       tick;
    logic [6:0] req;
    logic [2:0] currentFl;
    logic       doorOpen;
    logic       moving;
    logic       dirUp;
    logic [6:0] pending;

    modport master (
        output tick,
        output req,
        input  currentFl,
        input  doorOpen,
        input  moving,
        input  dirUp,
        input  pending
    );

    modport slave (
        input  tick,
        input  req,
        output currentFl,
        output doorOpen,
        output moving,
        output dirUp,
        output pending
    );
endinterface
`default_nettype wire

// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elevator_car_ctrl
// Brief    : SCAN car-motion controller: request capture, stepping, door dwell.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_car_ctrl #(
    parameter int TRAVEL = 4,
    parameter int DWELL  = 3
) (
    input  wire                clk,
    input  wire                reset,
    elevator_car_ctrl_if.slave bus
);

    localparam int C_CNT_MAX = (TRAVEL > DWELL) ? TRAVEL : DWELL;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_TRAVEL_LAST = C_CNT_W'(TRAVEL - 1);
    localparam logic [C_CNT_W-1:0] C_DWELL_LAST  = C_CNT_W'(DWELL - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE     = C_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOOR = 2'd1,
        ST_MOVE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           fl_q, fl_d;
    logic                 dir_up_q, dir_up_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]           pending_q, pending_d;
    logic                 door_open_q, door_open_d;
    logic                 moving_q, moving_d;

    logic [6:0] w_fl_onehot;
    logic [6:0] w_below_mask;
    logic [6:0] w_above_mask;
    logic       w_above;
    logic       w_below;
    logic       w_req_here;
    logic       w_pend_here;

    // Masks split the request vector around the current position.
    always_comb begin
        w_fl_onehot  = 7'd1 << fl_q;
        w_below_mask = w_fl_onehot - 7'd1;
        w_above_mask = ~(w_below_mask | w_fl_onehot);
        w_above      = |(pending_q & w_above_mask);
        w_below      = |(pending_q & w_below_mask);
        w_req_here   = |(bus.req & w_fl_onehot);
        w_pend_here  = |(pending_q & w_fl_onehot);
    end

    always_comb begin
        state_d   = state_q;
        fl_d      = fl_q;
        dir_up_d  = dir_up_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | bus.req;

        case (state_q)
            ST_IDLE: begin
                if (w_pend_here || w_req_here) begin
                    state_d   = ST_DOOR;
                    pending_d = (pending_q | bus.req) & ~w_fl_onehot;
                    cnt_d     = '0;
                end else if (dir_up_q && w_above) begin
                    state_d = ST_MOVE;
                    cnt_d   = '0;
                end else if (!dir_up_q && w_below) begin
                    state_d = ST_MOVE;
                    cnt_d   = '0;
                end else if (w_above) begin
                    dir_up_d = 1'b1;
                    state_d  = ST_MOVE;
                    cnt_d    = '0;
                end else if (w_below) begin
                    dir_up_d = 1'b0;
                    state_d  = ST_MOVE;
                    cnt_d    = '0;
                end
            end

            ST_MOVE: begin
                if (bus.tick) begin
                    if (cnt_q == C_TRAVEL_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        if (dir_up_q) begin
                            if (fl_q != 3'd6) fl_d = fl_q + 3'd1;
                        end else begin
                            if (fl_q != 3'd0) fl_d = fl_q - 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
            end

            ST_DOOR: begin
                // A call for the floor we are standing at holds the doors instead of queueing.
                pending_d = pending_q | (bus.req & ~w_fl_onehot);
                if (w_req_here) begin
                    cnt_d = '0;
                end else if (bus.tick) begin
                    if (cnt_q == C_DWELL_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        door_open_d = (state_d == ST_DOOR);
        moving_d    = (state_d == ST_MOVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fl_q        <= 3'd0;
            dir_up_q    <= 1'b1;
            cnt_q       <= '0;
            pending_q   <= 7'd0;
            door_open_q <= 1'b0;
            moving_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fl_q        <= fl_d;
            dir_up_q    <= dir_up_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            door_open_q <= door_open_d;
            moving_q    <= moving_d;
        end
    end

    assign bus.currentFl = fl_q;
    assign bus.doorOpen  = door_open_q;
    assign bus.moving    = moving_q;
    assign bus.dirUp     = dir_up_q;
    assign bus.pending   = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_car_ctrl
// Brief    : Scenario and random-stimulus bench with a floor-level car model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_car_ctrl;

    localparam int TRAVEL = 2;
    localparam int DWELL  = 2;
    localparam int M_IDLE = 0;
    localparam int M_DOOR = 1;
    localparam int M_MOVE = 2;

    logic clk;
    logic reset;

    elevator_car_ctrl_if bus ();

    elevator_car_ctrl #(
        .TRAVEL (TRAVEL),
        .DWELL  (DWELL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_bad;
    int cyc;
    int door_cycles;
    int stops[$];
    int chg_cyc[$];
    int chg_val[$];
    logic       door_prev;
    logic [2:0] fl_prev;

    // Reference car: position, travel sense, mode and ticks still to wait.
    int       m_fl;
    bit       m_dir;
    int       m_mode;
    int       m_left;
    bit [6:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rs, input bit [6:0] rq, input bit tk);
        bit up_work;
        bit dn_work;
        bit here;
        if (rs) begin
            m_fl = 0; m_dir = 1'b1; m_mode = M_IDLE; m_left = 0; m_pend = '0;
            return;
        end
        up_work = 1'b0;
        dn_work = 1'b0;
        for (int f = 0; f < 7; f++) begin
            if (m_pend[f] && f > m_fl) up_work = 1'b1;
            if (m_pend[f] && f < m_fl) dn_work = 1'b1;
        end
        case (m_mode)
            M_IDLE: begin
                here   = m_pend[m_fl] || rq[m_fl];
                m_pend = m_pend | rq;
                if (here) begin
                    m_pend[m_fl] = 1'b0;
                    m_mode = M_DOOR;
                    m_left = DWELL;
                end else if (up_work && (m_dir || !dn_work)) begin
                    m_dir = 1'b1; m_mode = M_MOVE; m_left = TRAVEL;
                end else if (dn_work) begin
                    m_dir = 1'b0; m_mode = M_MOVE; m_left = TRAVEL;
                end
            end
            M_MOVE: begin
                m_pend = m_pend | rq;
                if (tk) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_fl   = m_dir ? ((m_fl < 6) ? m_fl + 1 : 6) : ((m_fl > 0) ? m_fl - 1 : 0);
                        m_mode = M_IDLE;
                    end
                end
            end
            default: begin
                for (int f = 0; f < 7; f++)
                    if (f != m_fl && rq[f]) m_pend[f] = 1'b1;
                if (rq[m_fl]) begin
                    m_left = DWELL;
                end else if (tk) begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic step(input logic [6:0] rq, input logic tk, input logic rs);
        bus.req  = rq;
        bus.tick = tk;
        reset    = rs;
        @(posedge clk);
        model_step(rs, rq, tk);
        cyc++;
        #1;
        chk("fl", bus.currentFl, m_fl);
        chk("door", bus.doorOpen, m_mode == M_DOOR);
        chk("moving", bus.moving, m_mode == M_MOVE);
        chk("dir", bus.dirUp, m_dir);
        chk("pending", bus.pending, m_pend);
        chk("fl_range", bus.currentFl <= 3'd6, 1);
        if (bus.doorOpen === 1'b1) door_cycles++;
        if (bus.doorOpen === 1'b1 && door_prev !== 1'b1) stops.push_back(int'(bus.currentFl));
        if (bus.currentFl !== fl_prev) begin
            chg_cyc.push_back(cyc);
            chg_val.push_back(int'(bus.currentFl));
        end
        door_prev = bus.doorOpen;
        fl_prev   = bus.currentFl;
        @(negedge clk);
        bus.req = '0;
    endtask

    task automatic run_quiet(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step('0, 1'b1, 1'b0);
            done = (m_mode == M_IDLE) && (m_pend == '0);
        end
        chk({tag, "_quiet"}, done, 1);
    endtask

    task automatic wait_mode(input string tag, input int mode, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step('0, 1'b1, 1'b0);
            done = (m_mode == mode);
        end
        chk({tag, "_reached"}, done, 1);
    endtask

    task automatic clear_logs();
        stops.delete();
        chg_cyc.delete();
        chg_val.delete();
        door_cycles = 0;
    endtask

    initial begin
        int req_cyc;
        logic [6:0] rq;
        n_total = 0; n_bad = 0; cyc = 0; door_cycles = 0;
        door_prev = 1'b0; fl_prev = 3'd0;
        m_fl = 0; m_dir = 1'b1; m_mode = M_IDLE; m_left = 0; m_pend = '0;
        bus.req = '0; bus.tick = 1'b1; reset = 1'b1;
        @(negedge clk);

        // Reset with a request present: it must be dropped.
        step(7'b0001000, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step('0, 1'b1, 1'b0);
            chk("t1_fl", bus.currentFl, 0);
            chk("t1_door", bus.doorOpen, 0);
            chk("t1_moving", bus.moving, 0);
            chk("t1_dir", bus.dirUp, 1);
            chk("t1_pending", bus.pending, 0);
        end

        // Single call to position 3 from 0.
        clear_logs();
        req_cyc = cyc + 1;
        step(7'b0001000, 1'b1, 1'b0);
        chk("t2_pending_capture", bus.pending, 7'b0001000);
        run_quiet("t2", 60);
        chk("t2_nsteps", chg_val.size(), 3);
        if (chg_val.size() == 3) begin
            chk("t2_step0", chg_val[0], 1);
            chk("t2_step1", chg_val[1], 2);
            chk("t2_step2", chg_val[2], 3);
            chk("t2_first_lat", chg_cyc[0] - req_cyc, 3);
            chk("t2_gap01", chg_cyc[1] - chg_cyc[0], 3);
            chk("t2_gap12", chg_cyc[2] - chg_cyc[1], 3);
        end
        chk("t2_door_cycles", door_cycles, 2);
        chk("t2_pending_end", bus.pending, 0);

        // Both ends from 3 heading up: top first, then bottom.
        clear_logs();
        step(7'b1000001, 1'b1, 1'b0);
        run_quiet("t3", 120);
        chk("t3_nstops", stops.size(), 2);
        if (stops.size() == 2) begin
            chk("t3_stop0", stops[0], 6);
            chk("t3_stop1", stops[1], 0);
        end
        chk("t3_dir", bus.dirUp, 0);
        chk("t3_fl", bus.currentFl, 0);
        chk("t3_pending_end", bus.pending, 0);

        // Same-floor call during the first dwell tick restarts the dwell.
        step(7'b0000100, 1'b1, 1'b0);
        wait_mode("t4_door", M_DOOR, 40);
        door_cycles = 1;
        step(7'b0000100, 1'b1, 1'b0);
        chk("t4_pending2", bus.pending[2], 0);
        run_quiet("t4", 40);
        chk("t4_door_cycles", door_cycles, 3);
        chk("t4_fl", bus.currentFl, 2);

        // Call at 4 arriving while travelling 1->2 on the way to 5.
        step(7'b0000010, 1'b1, 1'b0);
        run_quiet("t5a", 40);
        chk("t5_start_fl", bus.currentFl, 1);
        clear_logs();
        step(7'b0100000, 1'b1, 1'b0);
        wait_mode("t5_move", M_MOVE, 20);
        step(7'b0010000, 1'b1, 1'b0);
        run_quiet("t5", 80);
        chk("t5_nstops", stops.size(), 2);
        if (stops.size() == 2) begin
            chk("t5_stop0", stops[0], 4);
            chk("t5_stop1", stops[1], 5);
        end

        // Reset while moving up from 4 with position 5 outstanding.
        step(7'b0010000, 1'b1, 1'b0);
        wait_mode("t6_door", M_DOOR, 40);
        step(7'b0100000, 1'b1, 1'b0);
        wait_mode("t6_move", M_MOVE, 20);
        chk("t6_pre_fl", bus.currentFl, 4);
        chk("t6_pre_pending", bus.pending, 7'b0100000);
        chk("t6_pre_moving", bus.moving, 1);
        step('0, 1'b1, 1'b1);
        chk("t6_fl", bus.currentFl, 0);
        chk("t6_pending", bus.pending, 0);
        chk("t6_moving", bus.moving, 0);
        chk("t6_door", bus.doorOpen, 0);
        chk("t6_dir", bus.dirUp, 1);
        for (int i = 0; i < 10; i++) begin
            step('0, 1'b1, 1'b0);
            chk("t6_hold_fl", bus.currentFl, 0);
            chk("t6_hold_moving", bus.moving, 0);
        end

        // Random calls with an irregular timebase and occasional resets.
        for (int i = 0; i < 600; i++) begin
            rq = '0;
            if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, 6)] = 1'b1;
            if ($urandom_range(0, 19) == 0) rq[$urandom_range(0, 6)] = 1'b1;
            step(rq, ($urandom_range(0, 3) != 0), ($urandom_range(0, 249) == 0));
        end
        run_quiet("rand", 300);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/elevator_car_ctrl.md
# elevator_car_ctrl

Car-motion controller for the elevator simulator. It stores hall and cab requests, moves the car one position at a time, and dwells with the doors open at each requested stop. Its `currentFl` output drives the door-lamp decoder and the display logic. It is therefore the producer end of the `currentFl` position bus.

## Interface

Parameters:
- `TRAVEL`, default 4: number of `tick` strobes to move one position.
- `DWELL`, default 3: number of `tick` strobes the doors stay open per stop.

Ports:
- `clk`  in  1: system clock. One clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `tick`  in  1: one-cycle timebase strobe. Travel and dwell counters advance only on `tick`.
- `req`  in  7: request pulses, bit i = position i. Already synchronized and single-cycle.
- `currentFl`  out  3: car position code, 0..6. Code 7 is never driven.
- `doorOpen`  out  1: high while in DOOR state.
- `moving`  out  1: high while in MOVE state.
- `dirUp`  out  1: current or last travel direction. 1 = up.
- `pending`  out  7: registered outstanding requests.

## Operation

States:
- IDLE
- DOOR
- MOVE

Request capture, every cycle:
- `pending |= req`.
- Exception: in DOOR, `req[currentFl]` does not set its bit; it reloads the dwell counter to 0 instead.
- In IDLE, `req[currentFl]` is acted on the same cycle (see IDLE below).

Direction sets:
- `above` = any `pending` bit with index > `currentFl`.
- `below` = any `pending` bit with index < `currentFl`.

IDLE:
- If `pending[currentFl]` or `req[currentFl]`: go to DOOR, clear bit `currentFl`, clear the dwell counter.
- Else if `dirUp` and `above`: go to MOVE (up).
- Else if `!dirUp` and `below`: go to MOVE (down).
- Else if `above`: set `dirUp=1`, go to MOVE.
- Else if `below`: set `dirUp=0`, go to MOVE.
- Else stay in IDLE.
- Entering MOVE clears the travel counter.

MOVE:
- On each `tick`, the travel counter increments.
- When it reaches `TRAVEL-1` on a `tick`: `currentFl` steps ±1 per `dirUp`, the counter clears, and the state becomes IDLE.
- The IDLE decision on the following cycle handles stop versus continue, so every step costs one extra clk cycle.
- `currentFl` saturates: it never goes above 6 or below 0. It cannot underflow because MOVE is entered only when `above` or `below` is set.

DOOR:
- On each `tick`, the dwell counter increments.
- When it reaches `DWELL-1` on a `tick`: go to IDLE.

Reset, mid-operation included:
- State = IDLE.
- `currentFl` = 0.
- `pending` = 0.
- `dirUp` = 1.
- Counters = 0.
- `doorOpen` = 0, `moving` = 0.
- Requests arriving in the reset cycle are dropped.

## Timing

- All outputs are registered and change only on `clk` edges.
- Request to effect:
  - A `req` pulse appears in `pending` the cycle after capture.
  - In IDLE, the state leaves IDLE on the next edge after the request.
- Step latency:
  - MOVE entry to `currentFl` update = `TRAVEL` ticks.
  - Then 1 clk cycle in IDLE, then the next MOVE or DOOR.
- Dwell:
  - `doorOpen` stays high from DOOR entry through the edge of the `DWELL`-th tick.
  - A same-floor `req` during DOOR restarts the full dwell.
- `tick` held high continuously is legal: counters advance every clk.
- A `req` bit set for a position the car is passing is served when the car arrives at that position (SCAN order).
- A simultaneous `req` for both ends while IDLE at position 3 with `dirUp=1`: the car goes up first.

## Test plan

Bench settings: `TRAVEL=2`, `DWELL=2`, `tick` tied high unless stated.

1. Reset, then idle:
   - Outputs: `currentFl=0`, `doorOpen=0`, `moving=0`, `dirUp=1`, `pending=0`.
   - All of these hold for 20 cycles with no `req`.
2. `req=7'b0001000` from position 0:
   - `currentFl` steps 1, 2, 3, each 3 clk apart.
   - At 3, `doorOpen` is high for 2 cycles.
   - Then IDLE with `pending=0`.
3. At position 3, IDLE, `dirUp=1`; pulse `req=7'b1000001` in one cycle:
   - The car goes to 6 first, opens the doors, then reverses.
   - `dirUp=0`, travels to 0, opens the doors.
   - `pending` ends at 0.
4. Doors open at position 2; pulse `req[2]` on dwell tick 1:
   - The dwell restarts; `doorOpen` lasts 3 cycles total.
   - `pending[2]` stays 0.
5. Car moving 1→2 toward 5; `req[4]` arrives mid-travel:
   - The car stops at 4 (`doorOpen`), then continues to 5.
   - `currentFl` never reads 7.
6. Assert `reset` while in MOVE at position 4 with `pending=7'b0100000`:
   - Next cycle: `currentFl=0`, `pending=0`, IDLE, and the car never moves.
